// File: rtl/load_store_unit_if.sv
// Bundles the execute-request, data-memory and writeback channels of the load/store unit.
// The slave modport is the LSU's view; the master modport is the surrounding pipeline/memory.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  // Execute-stage request
  logic                  ex_valid;
  logic                  ex_ready;
  logic                  ex_is_load;
  logic                  ex_is_store;
  logic [2:0]            ex_funct3;
  logic [ADDR_WIDTH-1:0] ex_addr;
  logic [31:0]           ex_wdata;

  // Data-memory port
  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_gnt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  // Writeback result
  logic                  wb_valid;
  logic                  wb_ready;
  logic [31:0]           wb_rdata;
  logic                  wb_misalign;

  modport slave (
    input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_wdata,
    output ex_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_rdata, wb_misalign,
    input  wb_ready
  );

  modport master (
    output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_wdata,
    input  ex_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_rdata, wb_misalign,
    output wb_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one outstanding access, byte-lane steering and load extension.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of force-aligning them.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;

  logic                  accept;
  logic                  active;
  logic                  trap;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            be;
  logic [31:0]           wdata_lane;

  assign accept = bus.ex_valid && bus.ex_ready;
  assign active = bus.ex_is_load || bus.ex_is_store;

  // Misaligned halfword/word offsets are dropped so the access lands on its natural boundary.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_addr = bus.ex_addr;
    case (bus.ex_funct3)
      F_H, F_HU: req_addr[0]   = 1'b0;
      F_W:       req_addr[1:0] = 2'b00;
      default:   ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misalign;
  logic misalign_q;

  always_comb begin
    req_misalign = 1'b0;
    case (bus.ex_funct3)
      F_H, F_HU: req_misalign = bus.ex_addr[0];
      F_W:       req_misalign = |bus.ex_addr[1:0];
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      misalign_q <= 1'b0;
    else if (accept) misalign_q <= req_misalign;
  end

  assign trap            = req_misalign;
  assign bus.wb_misalign = misalign_q;
`else
  assign trap            = 1'b0;
  assign bus.wb_misalign = 1'b0;
`endif

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F_B:     return {{24{b[7]}}, b};
      F_BU:    return {24'h0, b};
      F_H:     return {{16{h[15]}}, h};
      F_HU:    return {16'h0, h};
      F_W:     return word;
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    be = 4'b0000;
    case (funct3_q)
      F_B, F_BU: be = 4'b0001 << addr_q[1:0];
      F_H, F_HU: be = 4'b0011 << {addr_q[1], 1'b0};
      F_W:       be = 4'b1111;
      default:   ;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   wdata_lane = {4{wdata_q[7:0]}};
      2'b01:   wdata_lane = {2{wdata_q[15:0]}};
      default: wdata_lane = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && active) state_d = trap ? RESP : REQ;
      REQ:  if (bus.mem_gnt)      state_d = we_q ? RESP : WAIT;
      WAIT: if (bus.mem_rvalid)   state_d = RESP;
      RESP: if (bus.wb_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and a synchronous, active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= bus.ex_funct3;
        we_q     <= bus.ex_is_store;
        wdata_q  <= bus.ex_wdata;
        rdata_q  <= 32'h0;
      end else if (state_q == WAIT && bus.mem_rvalid) begin
        rdata_q <= extract(funct3_q, addr_q[1:0], bus.mem_rdata);
      end
    end
  end

  // Memory outputs are forced to zero outside REQ so idle/reset values are clean.
  assign bus.ex_ready  = (state_q == IDLE);
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = bus.mem_req && we_q;
  assign bus.mem_addr  = bus.mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_be    = bus.mem_req ? be : 4'b0000;
  assign bus.mem_wdata = bus.mem_we ? wdata_lane : 32'h0;
  assign bus.wb_valid  = (state_q == RESP);
  assign bus.wb_rdata  = rdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width of ex_addr and mem_addr.
REQ-002 Data width SHALL be fixed at 32 bits (RV32), with no parameter.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ex_valid  in  1, ex_ready  out  1: request handshake from the execute stage.
REQ-006 ex_is_load  in  1, ex_is_store  in  1, ex_funct3  in  3: access type and size (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 ex_addr  in  ADDR_WIDTH  byte address; ex_wdata  in  32  store data, right-justified.
REQ-008 mem_req  out  1, mem_we  out  1, mem_gnt  in  1: data-memory request handshake.
REQ-009 mem_addr  out  ADDR_WIDTH  word-aligned address; mem_be  out  4  byte enables; mem_wdata  out  32  lane-aligned store data.
REQ-010 mem_rvalid  in  1, mem_rdata  in  32: load response word.
REQ-011 wb_valid  out  1, wb_ready  in  1, wb_rdata  out  32, wb_misalign  out  1: result to writeback.

Function
REQ-012 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-013 ex_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where ex_valid && ex_ready.
REQ-014 On acceptance, addr, funct3, load/store and wdata SHALL be registered, and the FSM SHALL move IDLE->REQ.
REQ-015 If both ex_is_load and ex_is_store are set, the access SHALL be a store; if neither is set, the request SHALL be consumed with no memory or writeback activity.
REQ-016 In REQ, mem_req SHALL be 1 with stable mem_addr/mem_be/mem_we/mem_wdata until mem_gnt; then a load SHALL go to WAIT and a store to RESP.
REQ-017 In WAIT, mem_rvalid SHALL capture the extracted load data into wb_rdata and move to RESP; mem_rvalid SHALL be ignored in every other state.
REQ-018 In RESP, wb_valid SHALL be 1 and wb_rdata/wb_misalign held until wb_ready, then the FSM SHALL go to IDLE.
REQ-019 Store results SHALL have wb_rdata = 0.
REQ-020 mem_addr SHALL equal {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-021 mem_be SHALL be: B/BU 0001<<addr[1:0]; H/HU 0011<<{addr[1],1'b0}; W 1111; other funct3 0000.
REQ-022 mem_wdata SHALL be {4{wdata[7:0]}} for B, {2{wdata[15:0]}} for H, and wdata for W.
REQ-023 Load data SHALL be selected from the lane at addr[1:0]: B sign-extends bit 7, BU zero-extends, H sign-extends bit 15, HU zero-extends, W passes through; funct3 011/110/111 SHALL return 0.
REQ-024 An access is misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-025 Load latency with mem_gnt=1 in REQ, mem_rvalid=1 in the first WAIT cycle and wb_ready=1 SHALL be: wb_valid high in the third cycle after acceptance; a store SHALL reach RESP in the second.

Reset
REQ-026 While rst_n=0 the FSM SHALL go to IDLE and outputs SHALL be: ex_ready=1 (after reset), mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_rdata=0, wb_misalign=0.
REQ-027 Reset in any state SHALL abandon the transaction; a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN: when defined, a misaligned access SHALL issue no mem_req and go REQ-free from IDLE straight to RESP with wb_misalign=1 and wb_rdata=0.
REQ-029 When LSU_MISALIGN_TRAP_EN is undefined, the misaligned offset bits SHALL be cleared (H: addr[0]=0; W: addr[1:0]=0), the access SHALL proceed normally, and wb_misalign SHALL be tied 0.

Verification
REQ-030 SB addr=0x103, wdata=0x12345678 -> mem_addr=0x100, mem_be=1000, mem_wdata=0x78787878, mem_we=1.
REQ-031 LB addr=0x101, mem_rdata=0x0000F000 -> wb_rdata=0xFFFFFFF0; LBU at the same address -> 0x000000F0.
REQ-032 LH addr=0x202, mem_rdata=0x8001ABCD -> wb_rdata=0xFFFF8001; mem_gnt held low 3 cycles -> mem_req and mem_addr stay stable.
REQ-033 LW addr=0x106 with the macro defined -> no mem_req, wb_misalign=1; with the macro undefined -> mem_addr=0x104, wb_misalign=0.
REQ-034 wb_ready held 0 for 4 cycles in RESP -> wb_valid and wb_rdata stay stable and ex_ready=0; rst_n=0 in WAIT -> IDLE next edge and a following mem_rvalid produces no wb_valid.
